eeprom_page_array: RTL and testbench
====================================

# eeprom_page_array

Parametrised byte-addressed EEPROM storage core for the Avalon I2C EEPROM slave: it replaces the single fixed 8-byte page with `PAGE_NUM` pages of `PAGE_BYTES` bytes. Writes are staged in a page buffer with in-page address wrap, then committed after a modelled write-cycle time (tWR) during which the core reports busy. Sequential reads auto-increment across the whole array. The I2C protocol FSM drives it one byte operation at a time.

## Interface
- `DATA_W`, 8, byte width.
- `PAGE_BYTES`, 8, bytes per page; power of two, ≥2.
- `PAGE_NUM`, 32, pages; power of two.
- `TWR_CYCLES`, 16, tWR wait length in clocks; ≥1.
- `ADDR_W` is a localparam: log2(`PAGE_BYTES`·`PAGE_NUM`). `OFS_W` is a localparam: log2(`PAGE_BYTES`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cs`  in  1  qualifies `start`, `write`, `rd_en`.
- `start`  in  1  load address pointer from `addr_i`.
- `addr_i`  in  `ADDR_W`  start address.
- `write`  in  1  stage `data_i` into the page buffer.
- `data_i`  in  `DATA_W`  write byte.
- `rd_en`  in  1  read the byte at the pointer.
- `stop`  in  1  end of transfer; launches commit if bytes are staged. Not gated by `cs`.
- `data_o`  out  `DATA_W`  registered read data.
- `ack`  out  1  one-cycle pulse: the previous cycle's operation was accepted.
- `busy`  out  1  write cycle in progress.

## Operation
- Internal state: pointer `ptr[ADDR_W]`; page buffer of `PAGE_BYTES` bytes; valid mask `mask[PAGE_BYTES]`; FSM with states IDLE, WAIT and COMMIT.
- An operation is accepted only in IDLE. At most one operation is accepted per cycle, with priority stop > start > write > read. Lower-priority requests in the same cycle are dropped and produce no ack.
- **start** (`cs`&`start`):
  - `ptr`<=`addr_i`.
  - `mask` is cleared, which discards any uncommitted staged bytes.
- **write** (`cs`&`write`):
  - buffer[ptr[OFS_W-1:0]]<=`data_i` and the matching mask bit is set.
  - Only the low `OFS_W` bits of `ptr` increment, modulo `PAGE_BYTES`. The page bits never change during a write burst.
  - Writing more than `PAGE_BYTES` bytes overwrites earlier staged bytes.
- **read** (`cs`&`rd_en`&!`write`):
  - `data_o`<=array[ptr].
  - The full `ptr` increments, wrapping from the last address to 0.
  - Reads return committed array contents only, never staged bytes.
- **stop**:
  - If `mask`≠0: go IDLE→WAIT and ack.
  - If `mask`=0: ack only; no state change and no busy.
- **WAIT**: a counter runs `TWR_CYCLES` cycles, then the FSM enters COMMIT.
- **COMMIT**:
  - Runs `PAGE_BYTES` cycles, one offset per cycle starting at 0.
  - If mask[k] is set, array[{page, k}]<=buffer[k], where page = ptr[ADDR_W-1:OFS_W].
  - On exit `mask` is cleared and the FSM returns to IDLE.
- While busy, `start`, `write`, `rd_en` and `stop` are ignored: no ack and no state change.
- Reset:
  - `ptr`=0, `mask`=0, FSM=IDLE, `busy`=0, `data_o`=0, `ack`=0.
  - Array contents are not reset.
  - Reset during WAIT leaves the array untouched.
  - Reset during COMMIT leaves offsets already processed written and the rest unchanged.

## Timing
- Edge N is the accepting edge. `ack` is high for exactly the cycle after edge N.
- Read: `data_o` is valid from the cycle after edge N and is held until the next accepted read or reset.
- Stop with staged data: `busy` is high from the cycle after edge N for exactly `TWR_CYCLES`+`PAGE_BYTES` cycles, then deasserts.
- The first cycle with `busy`=0 accepts operations. Reads issued then return the committed data.
- `busy` and `ack` are registered outputs. No combinational path from inputs to outputs.

## Test plan
All scenarios use `PAGE_BYTES`=8, `PAGE_NUM`=4, `TWR_CYCLES`=4 (`ADDR_W`=5).

1. Assert `rst` mid-cycle with no clock edge -> `data_o`=0, `ack`=0, `busy`=0 immediately. A subsequent read with no start returns array[0].
2. Page wrap:
   - Stimulus: start 0x05; write A0,A1,A2,A3; stop.
   - `busy` is high 12 cycles.
   - Read back from 0x00: array[0x00]=A3, array[0x05..0x07]=A0..A2, array[0x01..0x04] unchanged.
3. Overflow: start 0x08, write bytes 0x10..0x19 (10 bytes), stop -> array[0x08]=0x18, array[0x09]=0x19, array[0x0A..0x0F]=0x12..0x17.
4. Array wrap: preload array[0x1F]=0x5A and array[0x00]=0xC3; start 0x1F; read twice -> `data_o`=0x5A then 0xC3, each with a one-cycle ack.
5. Busy lockout and priority:
   - During busy, pulse start, write, rd_en and stop -> no ack; `ptr`, `mask` and `data_o` unchanged.
   - In IDLE, assert start and write together -> only start is accepted; the byte is not staged.
6. Abort cases:
   - Stop with empty mask -> ack, `busy` stays 0.
   - Write 0x77 to 0x02, stop, assert `rst` 2 cycles into WAIT -> array[0x02] is unchanged.
   - Start after a write without stop -> the staged byte is discarded; a later stop does not raise busy.

Source files
------------

// File: rtl/eeprom_page_array.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_page_array
// Description : Paged EEPROM storage core. Byte writes are staged in a page
//               buffer with in-page address wrap. A stop commits the staged
//               bytes after a modelled tWR wait, and busy is raised meanwhile.
//               Sequential reads auto-increment across the whole array.
// Revision    : 1.0 - initial release
// ============================================================================
module eeprom_page_array #(
    parameter int DATA_W     = 8,
    parameter int PAGE_BYTES = 8,
    parameter int PAGE_NUM   = 32,
    parameter int TWR_CYCLES = 16,
    localparam int ADDR_W    = $clog2(PAGE_BYTES * PAGE_NUM),
    localparam int OFS_W     = $clog2(PAGE_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              write,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en,
    input  logic              stop,
    output logic [DATA_W-1:0] data_o,
    output logic              ack,
    output logic              busy
);

    localparam int DEPTH   = PAGE_BYTES * PAGE_NUM;
    localparam int CNT_MAX = (TWR_CYCLES > PAGE_BYTES) ? TWR_CYCLES : PAGE_BYTES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_twr_last  = CNT_W'(TWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_page_last = CNT_W'(PAGE_BYTES - 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_wait   = 2'd1;
    localparam logic [1:0] c_commit = 2'd2;

    // Control and datapath state
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_ptr;
    logic [PAGE_BYTES-1:0] r_mask;
    logic [DATA_W-1:0] r_buf [PAGE_BYTES];
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data;
    logic              r_ack;
    logic              r_busy;

    // Decoded requests and derived controls
    logic              w_idle;
    logic              w_acc_stop;
    logic              w_acc_start;
    logic              w_acc_write;
    logic              w_acc_read;
    logic              w_launch;
    logic              w_wait_done;
    logic              w_commit_done;
    logic              w_ack_next;
    logic              w_busy_next;
    logic              w_mem_we;
    logic [OFS_W-1:0]  w_wr_ofs;
    logic [OFS_W-1:0]  w_cm_ofs;
    logic [ADDR_W-1:0] w_cm_addr;

    // Request arbitration: only in IDLE, one operation per cycle, stop > start > write > read
    always_comb begin
        w_idle      = (r_state == c_idle);
        w_acc_stop  = w_idle & stop;
        w_acc_start = w_idle & ~stop & cs & start;
        w_acc_write = w_idle & ~stop & cs & ~start & write;
        w_acc_read  = w_idle & ~stop & cs & ~start & ~write & rd_en;
        w_launch    = w_acc_stop & (|r_mask);
        w_wait_done   = (r_cnt == c_twr_last);
        w_commit_done = (r_cnt == c_page_last);
        w_wr_ofs    = r_ptr[OFS_W-1:0];
        w_cm_ofs    = r_cnt[OFS_W-1:0];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_launch) begin
                    w_state_next = c_wait;
                end
            end
            c_wait: begin
                if (w_wait_done) begin
                    w_state_next = c_commit;
                end
            end
            c_commit: begin
                if (w_commit_done) begin
                    w_state_next = c_idle;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    // FSM outputs: next values of the registered flags and the commit write port
    always_comb begin
        w_ack_next  = w_acc_stop | w_acc_start | w_acc_write | w_acc_read;
        w_busy_next = (w_state_next != c_idle);
        w_mem_we    = (r_state == c_commit) & r_mask[w_cm_ofs];
        // Commit target keeps the page bits of the pointer and walks the offset
        w_cm_addr              = r_ptr;
        w_cm_addr[OFS_W-1:0]   = w_cm_ofs;
    end

    // Phase counter: restarts on every state change, runs while not idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state != c_idle) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Address pointer and staged-byte mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_mask <= '0;
        end else begin
            if (w_acc_start) begin
                r_ptr  <= addr_i;
                r_mask <= '0;
            end else if (w_acc_write) begin
                // Only the in-page offset advances; the page stays fixed during a burst
                r_ptr[OFS_W-1:0]  <= w_wr_ofs + 1'b1;
                r_mask[w_wr_ofs]  <= 1'b1;
            end else if (w_acc_read) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if ((r_state == c_commit) && w_commit_done) begin
                r_mask <= '0;
            end
        end
    end

    // Registered read data, held until the next accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_acc_read) begin
            r_data <= r_mem[r_ptr];
        end
    end

    // Registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ack  <= w_ack_next;
            r_busy <= w_busy_next;
        end
    end

    // Page buffer staging and array commit; storage contents survive reset
    always_ff @(posedge clk) begin
        if (w_acc_write) begin
            r_buf[w_wr_ofs] <= data_i;
        end
        if (w_mem_we) begin
            r_mem[w_cm_addr] <= r_buf[w_cm_ofs];
        end
    end

    assign data_o = r_data;
    assign ack    = r_ack;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_page_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_eeprom_page_array
// Description : Self-checking bench for eeprom_page_array (8-byte pages,
//               4 pages, tWR of 4 clocks). Expected acks and read bytes are
//               queued when an operation is driven and compared when the DUT
//               answers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_page_array;

    localparam int DATA_W     = 8;
    localparam int PAGE_BYTES = 8;
    localparam int PAGE_NUM   = 4;
    localparam int TWR_CYCLES = 4;
    localparam int ADDR_W     = 5;
    localparam int BUSY_LEN   = TWR_CYCLES + PAGE_BYTES;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs;
    logic              start;
    logic [ADDR_W-1:0] addr_i;
    logic              write;
    logic [DATA_W-1:0] data_i;
    logic              rd_en;
    logic              stop;
    logic [DATA_W-1:0] data_o;
    logic              ack;
    logic              busy;

    typedef struct {
        int         due;
        bit         is_read;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tb_mem [32];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    eeprom_page_array #(
        .DATA_W     (DATA_W),
        .PAGE_BYTES (PAGE_BYTES),
        .PAGE_NUM   (PAGE_NUM),
        .TWR_CYCLES (TWR_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .start  (start),
        .addr_i (addr_i),
        .write  (write),
        .data_i (data_i),
        .rd_en  (rd_en),
        .stop   (stop),
        .data_o (data_o),
        .ack    (ack),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected acks
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each expected ack is due in the cycle after its accepting edge
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                n_checks++;
                if (ack !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ack_missing: ack=%b required 1 (cycle %0d)", ack, cyc);
                end else if (exp_q[0].is_read) begin
                    n_checks++;
                    if (data_o !== exp_q[0].data) begin
                        n_errors++;
                        $display("FAIL read_data: data_o=%h required %h (cycle %0d)",
                                 data_o, exp_q[0].data, cyc);
                    end
                end
                void'(exp_q.pop_front());
            end else if (ack !== 1'b0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: ack=%b required 0 (cycle %0d)", ack, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // Drive one set of inputs for exactly one clock edge (call at posedge+1)
    task automatic drive(input logic c, s, input logic [4:0] a, input logic w,
                         input logic [7:0] d, input logic r, p);
        cs = c; start = s; addr_i = a; write = w; data_i = d; rd_en = r; stop = p;
        @(posedge clk); #1;
        cs = 1'b0; start = 1'b0; write = 1'b0; rd_en = 1'b0; stop = 1'b0;
    endtask

    task automatic op_start(input logic [4:0] a);
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b1, 1'b1, a, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic op_write(input logic [7:0] d);
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b1, 1'b0, 5'd0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic op_read(input int a);
        exp_q.push_back('{cyc + 1, 1'b1, tb_mem[a]});
        drive(1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Stop and report how many sampled cycles busy stayed high (bounded)
    task automatic op_stop(output int n);
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_power_up;
        rst = 1'b1; cs = 1'b0; start = 1'b0; addr_i = '0; write = 1'b0;
        data_i = '0; rd_en = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (data_o !== 8'h00 || ack !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL power_up: data_o=%h ack=%b busy=%b required 00 0 0", data_o, ack, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic init_array;
        int n;
        for (int p = 0; p < PAGE_NUM; p++) begin
            op_start(5'(p * 8));
            for (int k = 0; k < PAGE_BYTES; k++) begin
                op_write(init_val(p * 8 + k));
                tb_mem[p * 8 + k] = init_val(p * 8 + k);
            end
            op_stop(n);
            n_checks++;
            if (n !== BUSY_LEN) begin
                n_errors++;
                $display("FAIL init_busy_len: busy cycles=%0d required %0d", n, BUSY_LEN);
            end
        end
    endtask

    task automatic test_reset;
        op_start(5'd3);
        op_read(3);
        #6;
        n_checks++;
        if (ack !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_pre_ack: ack=%b required 1", ack);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_o !== 8'h00 || ack !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: data_o=%h ack=%b busy=%b required 00 0 0", data_o, ack, busy);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        op_read(0);
    endtask

    task automatic test_page_wrap;
        int n;
        op_start(5'h05);
        op_write(8'hA0);
        op_write(8'hA1);
        op_write(8'hA2);
        op_write(8'hA3);
        op_stop(n);
        n_checks++;
        if (n !== 12) begin
            n_errors++;
            $display("FAIL page_wrap_busy_len: busy cycles=%0d required 12", n);
        end
        tb_mem[0] = 8'hA3;
        tb_mem[5] = 8'hA0;
        tb_mem[6] = 8'hA1;
        tb_mem[7] = 8'hA2;
        op_start(5'h00);
        for (int i = 0; i < 8; i++) op_read(i);
    endtask

    task automatic test_overflow;
        int n;
        op_start(5'h08);
        for (int i = 0; i < 10; i++) op_write(8'(8'h10 + i));
        op_stop(n);
        n_checks++;
        if (n !== 12) begin
            n_errors++;
            $display("FAIL overflow_busy_len: busy cycles=%0d required 12", n);
        end
        tb_mem[8'h08] = 8'h18;
        tb_mem[8'h09] = 8'h19;
        for (int i = 2; i < 8; i++) tb_mem[8 + i] = 8'(8'h10 + i);
        op_start(5'h08);
        for (int i = 0; i < 8; i++) op_read(8 + i);
    endtask

    task automatic test_array_wrap;
        int n;
        op_start(5'h1F);
        op_write(8'h5A);
        op_stop(n);
        tb_mem[31] = 8'h5A;
        op_start(5'h00);
        op_write(8'hC3);
        op_stop(n);
        tb_mem[0] = 8'hC3;
        op_start(5'h1F);
        op_read(31);
        op_read(0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (ack !== 1'b0 || data_o !== 8'hC3) begin
            n_errors++;
            $display("FAIL array_wrap_hold: ack=%b data_o=%h required 0 c3", ack, data_o);
        end
    endtask

    task automatic test_busy_lockout;
        int n;
        logic [7:0] d0;
        op_start(5'h10);
        op_write(8'h33);
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        d0 = data_o;
        drive(1'b1, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 1'b1, 8'h99, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (ack !== 1'b0 || busy !== 1'b1 || data_o !== d0) begin
            n_errors++;
            $display("FAIL busy_ignore: ack=%b busy=%b data_o=%h required 0 1 %h", ack, busy, data_o, d0);
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (n !== BUSY_LEN - 4) begin
            n_errors++;
            $display("FAIL busy_remaining: busy cycles=%0d required %0d", n, BUSY_LEN - 4);
        end
        tb_mem[16] = 8'h33;
        // Pointer must still be 0x11: the locked-out start/read changed nothing
        op_read(17);
        op_stop(n);
        n_checks++;
        if (n !== 0) begin
            n_errors++;
            $display("FAIL lockout_mask: busy cycles=%0d required 0", n);
        end
        // start + write together: only start is taken
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b1, 1'b1, 5'd24, 1'b1, 8'hEE, 1'b0, 1'b0);
        op_stop(n);
        n_checks++;
        if (n !== 0) begin
            n_errors++;
            $display("FAIL start_write_priority: busy cycles=%0d required 0", n);
        end
        op_read(24);
        // stop + read together: only stop is taken, read dropped
        d0 = data_o;
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (data_o !== d0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_read_priority: data_o=%h busy=%b required %h 0", data_o, busy, d0);
        end
        op_read(25);
    endtask

    task automatic test_abort;
        int n;
        op_stop(n);
        n_checks++;
        if (n !== 0) begin
            n_errors++;
            $display("FAIL empty_stop: busy cycles=%0d required 0", n);
        end
        op_start(5'h02);
        op_write(8'h77);
        exp_q.push_back('{cyc + 1, 1'b0, 8'h00});
        drive(1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_busy: busy=%b required 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_reset: busy=%b ack=%b required 0 0", busy, ack);
        end
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        op_start(5'h02);
        op_read(2);
        // Staged byte discarded by a new start
        op_start(5'h04);
        op_write(8'h55);
        op_start(5'h04);
        op_stop(n);
        n_checks++;
        if (n !== 0) begin
            n_errors++;
            $display("FAIL discard_stop: busy cycles=%0d required 0", n);
        end
        op_read(4);
    endtask

    initial begin
        test_power_up();
        init_array();
        test_reset();
        test_page_wrap();
        test_overflow();
        test_array_wrap();
        test_busy_lockout();
        test_abort();
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_acks: outstanding=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
